out_stream_checker: RTL

- Synthesizable, parametrised checker for a processor output port, built for the pipelined-core test harness and for on-board bring-up.
- Captures every valid `OUT_Port` sample into a log FIFO and compares it against an internally generated expected sequence: Fibonacci, increment, or capture-only.
- Reports match and mismatch counts, details of the first error, and timeout, then a final pass/done verdict.

---
 rtl/out_stream_checker_pkg.sv | 16 +
 rtl/out_stream_checker_sync_fifo.sv | 77 +++++++
 rtl/out_stream_checker.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/out_stream_checker_pkg.sv
// chk_pkg: shared definitions for out_stream_checker.
//   - Mode encodings for the expected-sequence generator.
//   - FSM state type for the checker control.
package chk_pkg;

    localparam logic [1:0] MODE_FIB = 2'd0;
    localparam logic [1:0] MODE_INC = 2'd1;
    localparam logic [1:0] MODE_CAP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/out_stream_checker_sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through read.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   flush         - empties the FIFO; overrides read/write that cycle
//   wr_en/wr_data - push request and data
//   rd_en         - pop request (ignored when empty)
//   rd_data       - head entry, 0 when empty
//   empty, full   - status derived from the registered pointers
//   wr_drop       - a push was refused because the FIFO was full
module sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int LOG_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              wr_drop
);

    localparam int AW = $clog2(LOG_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [LOG_DEPTH];
    logic [DATA_W-1:0] mem_d [LOG_DEPTH];
    logic              do_rd, do_wr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_rd    = rd_en && !empty && !flush;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_wr    = wr_en && !flush && (!full || do_rd);
        wr_drop  = wr_en && !flush && full && !do_rd;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) begin
                mem_d[wr_ptr_q[AW-1:0]] = wr_data;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < LOG_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/out_stream_checker.sv
// out_stream_checker: monitors a processor output port, logs every accepted
// sample into a FIFO and checks it against a generated expected sequence
// (Fibonacci, increment, or capture-only).
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   start, mode, seed0/1,     - arm/re-arm; configuration sampled on start
//   exp_count
//   in_valid, in_data         - monitored stream
//   rd_en, rd_data            - FWFT log read port
//   log_empty/full/ovf        - log status, ovf sticky per run
//   busy, done, pass, timeout - run status and verdict
//   sample_cnt, mismatch_cnt  - run counters
//   err_idx/got/exp           - details of the first mismatch
module out_stream_checker
    import chk_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 16,
    parameter int LOG_DEPTH = 16,
    parameter int TIMEOUT   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    input  logic [CNT_W-1:0]  exp_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              log_empty,
    output logic              log_full,
    output logic              log_ovf,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [CNT_W-1:0]  err_idx,
    output logic [DATA_W-1:0] err_got,
    output logic [DATA_W-1:0] err_exp
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]     IDLE_ONE = IW'(1);
    localparam logic [IW-1:0]     IDLE_MAX = IW'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d;
    logic [CNT_W-1:0]  exp_count_q, exp_count_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]  mismatch_cnt_q, mismatch_cnt_d;
    logic [CNT_W-1:0]  err_idx_q, err_idx_d;
    logic [DATA_W-1:0] err_got_q, err_got_d, err_exp_q, err_exp_d;
    logic              timeout_q, timeout_d;
    logic              log_ovf_q, log_ovf_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic              accept, chk_en, fifo_drop;

    // A start in RUN restarts the run; its in_valid sample is discarded.
    assign accept = (state_q == S_RUN) && in_valid && !start;

    sync_fifo #(
        .DATA_W    (DATA_W),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_log (
        .clk     (clk),
        .rst     (rst),
        .flush   (start),
        .wr_en   (accept),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (log_empty),
        .full    (log_full),
        .wr_drop (fifo_drop)
    );

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        exp_a_d        = exp_a_q;
        exp_b_d        = exp_b_q;
        exp_count_d    = exp_count_q;
        sample_cnt_d   = sample_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        err_idx_d      = err_idx_q;
        err_got_d      = err_got_q;
        err_exp_d      = err_exp_q;
        timeout_d      = timeout_q;
        log_ovf_d      = log_ovf_q;
        idle_d         = idle_q;
        chk_en         = 1'b0;

        if (start) begin
            state_d        = S_RUN;
            mode_d         = mode;
            exp_a_d        = seed0;
            exp_b_d        = seed1;
            exp_count_d    = exp_count;
            sample_cnt_d   = '0;
            mismatch_cnt_d = '0;
            err_idx_d      = '0;
            err_got_d      = '0;
            err_exp_d      = '0;
            timeout_d      = 1'b0;
            log_ovf_d      = 1'b0;
            idle_d         = '0;
        end else if (state_q == S_RUN) begin
            if (in_valid) begin
                idle_d       = '0;
                sample_cnt_d = sample_cnt_q + CNT_ONE;
                case (mode_q)
                    MODE_FIB: begin
                        chk_en  = 1'b1;
                        exp_a_d = exp_b_q;
                        exp_b_d = exp_a_q + exp_b_q;
                    end
                    MODE_INC: begin
                        chk_en  = 1'b1;
                        exp_a_d = exp_a_q + DATA_ONE;
                    end
                    MODE_CAP: chk_en = 1'b0;
                    default:  chk_en = 1'b0;
                endcase
                if (chk_en && (in_data != exp_a_q)) begin
                    if (mismatch_cnt_q == '0) begin
                        err_idx_d = sample_cnt_q;
                        err_got_d = in_data;
                        err_exp_d = exp_a_q;
                    end
                    if (mismatch_cnt_q != '1) begin
                        mismatch_cnt_d = mismatch_cnt_q + CNT_ONE;
                    end
                end
                if ((exp_count_q != '0) && (sample_cnt_d == exp_count_q)) begin
                    state_d = S_DONE;
                end
                if (fifo_drop) begin
                    log_ovf_d = 1'b1;
                end
            end else begin
                // Only idle cycles count toward timeout, so a final sample
                // can never coincide with a timeout.
                idle_d = idle_q + IDLE_ONE;
                if (idle_d == IDLE_MAX) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            mode_q         <= '0;
            exp_a_q        <= '0;
            exp_b_q        <= '0;
            exp_count_q    <= '0;
            sample_cnt_q   <= '0;
            mismatch_cnt_q <= '0;
            err_idx_q      <= '0;
            err_got_q      <= '0;
            err_exp_q      <= '0;
            timeout_q      <= 1'b0;
            log_ovf_q      <= 1'b0;
            idle_q         <= '0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            exp_a_q        <= exp_a_d;
            exp_b_q        <= exp_b_d;
            exp_count_q    <= exp_count_d;
            sample_cnt_q   <= sample_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            err_idx_q      <= err_idx_d;
            err_got_q      <= err_got_d;
            err_exp_q      <= err_exp_d;
            timeout_q      <= timeout_d;
            log_ovf_q      <= log_ovf_d;
            idle_q         <= idle_d;
        end
    end

    assign busy         = (state_q == S_RUN);
    assign done         = (state_q == S_DONE);
    assign pass         = done && (mismatch_cnt_q == '0) && !timeout_q;
    assign timeout      = timeout_q;
    assign log_ovf      = log_ovf_q;
    assign sample_cnt   = sample_cnt_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign err_idx      = err_idx_q;
    assign err_got      = err_got_q;
    assign err_exp      = err_exp_q;

endmodule
